// File: rtl/game_ctrl.sv
// Game-flow controller for the ball/score block: button debounce, serve/point
// delays, pause, game-over detection and per-point ball speed-up.
module game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SERVE_DELAY     = 50000000,
  parameter int POINT_DELAY     = 25000000,
  parameter int PRESC_INIT      = 250000,
  parameter int PRESC_STEP      = 10000,
  parameter int PRESC_MIN       = 100000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        btn_start,
  input  logic [3:0]  p1_score,
  input  logic [3:0]  p2_score,
  input  logic        gamestop,
  output logic        start,
  output logic [21:0] prescaler,
  output logic [2:0]  state_o,
  output logic [1:0]  winner
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_POINT = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_reg, sync2_reg, db_level_reg, db_prev_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic [3:0]      prev_p1_reg, prev_p2_reg;
  logic            prev_gs_reg;
  logic            press, gs_rise, point;

  logic [2:0]  state_reg, state_next;
  logic [25:0] dly_reg, dly_next;
  logic        start_reg, start_next;
  logic [21:0] presc_reg, presc_next, presc_dec;
  logic [22:0] presc_diff;
  logic [1:0]  winner_reg, winner_next;

  // Button: 2-flop synchronizer, then a level debouncer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      db_level_reg <= 1'b0;
      db_prev_reg  <= 1'b0;
      db_cnt_reg   <= '0;
    end else begin
      sync1_reg   <= btn_start;
      sync2_reg   <= sync1_reg;
      db_prev_reg <= db_level_reg;
      if (sync2_reg == db_level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_MAX) begin
        db_level_reg <= sync2_reg;
        db_cnt_reg   <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  assign press = db_level_reg & ~db_prev_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_p1_reg <= '0;
      prev_p2_reg <= '0;
      prev_gs_reg <= 1'b0;
    end else begin
      prev_p1_reg <= p1_score;
      prev_p2_reg <= p2_score;
      prev_gs_reg <= gamestop;
    end
  end

  // The ball block clears the scores as it raises gamestop; that is not a point.
  assign gs_rise = gamestop & ~prev_gs_reg;
  assign point   = ((p1_score != prev_p1_reg) | (p2_score != prev_p2_reg)) & ~gs_rise;

  assign presc_diff = {1'b0, presc_reg} - 23'(PRESC_STEP);
  assign presc_dec  = (presc_diff[22] || (presc_diff[21:0] < 22'(PRESC_MIN)))
                      ? 22'(PRESC_MIN) : presc_diff[21:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= S_IDLE;
      dly_reg    <= '0;
      start_reg  <= 1'b0;
      presc_reg  <= 22'(PRESC_INIT);
      winner_reg <= 2'b00;
    end else begin
      state_reg  <= state_next;
      dly_reg    <= dly_next;
      start_reg  <= start_next;
      presc_reg  <= presc_next;
      winner_reg <= winner_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (press) state_next = S_SERVE;
      S_SERVE: if (dly_reg == 26'(SERVE_DELAY - 1)) state_next = S_PLAY;
      S_PLAY: begin
        if (gs_rise)    state_next = S_OVER;
        else if (point) state_next = S_POINT;
        else if (press) state_next = S_HOLD;
      end
      S_HOLD:  if (press) state_next = S_PLAY;
      S_POINT: if (dly_reg == 26'(POINT_DELAY - 1)) state_next = S_PLAY;
      S_OVER:  if (press) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered outputs are derived from the upcoming state so they track it exactly.
  always_comb begin
    start_next  = (state_next == S_PLAY);
    presc_next  = presc_reg;
    winner_next = winner_reg;
    if ((state_next != state_reg) || !((state_reg == S_SERVE) || (state_reg == S_POINT)))
      dly_next = '0;
    else
      dly_next = dly_reg + 26'd1;
    if ((state_reg == S_IDLE) && (state_next == S_SERVE)) begin
      presc_next  = 22'(PRESC_INIT);
      winner_next = 2'b00;
    end
    if ((state_reg == S_PLAY) && (state_next == S_POINT))
      presc_next = presc_dec;
    if ((state_reg == S_PLAY) && (state_next == S_OVER))
      winner_next = (prev_p1_reg > prev_p2_reg) ? 2'b01 : 2'b10;
  end

  assign start     = start_reg;
  assign prescaler = presc_reg;
  assign state_o   = state_reg;
  assign winner    = winner_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: the driver queues the expected state visits,
// and a monitor checks each state change, its outputs and the delay dwell times.
module tb_game_ctrl;
  localparam int DB = 4, SD = 10, PD = 6, PI = 100, PS = 30, PM = 20;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        btn_start = 1'b0;
  logic        gamestop = 1'b0;
  logic [3:0]  p1_score = 4'd0;
  logic [3:0]  p2_score = 4'd0;
  logic        start;
  logic [21:0] prescaler;
  logic [2:0]  state_o;
  logic [1:0]  winner;

  typedef struct {
    int st;
    int sta;
    int pr;
    int wn;
    int dw;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cycle = 0;
  int         last_cycle = 0;
  int         prev_dwell = -1;
  logic [2:0] last_state = 3'd0;
  int         npts = 0;

  game_ctrl #(
    .DEBOUNCE_CYCLES(DB), .SERVE_DELAY(SD), .POINT_DELAY(PD),
    .PRESC_INIT(PI), .PRESC_STEP(PS), .PRESC_MIN(PM)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .btn_start(btn_start),
    .p1_score(p1_score), .p2_score(p2_score), .gamestop(gamestop),
    .start(start), .prescaler(prescaler), .state_o(state_o), .winner(winner)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  // Speed after k points of the current game.
  function automatic int model_presc(int k);
    int v;
    v = PI - PS * k;
    return (v < PM) ? PM : v;
  endfunction

  function automatic void push(int st, int sta, int pr, int wn, int dw);
    exp_t e;
    e.st = st; e.sta = sta; e.pr = pr; e.wn = wn; e.dw = dw;
    exp_q.push_back(e);
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cycle);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (state_o !== last_state) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transition", int'(state_o), int'(last_state));
      end else begin
        e = exp_q.pop_front();
        $display("txn: state %0d->%0d start=%0d presc=%0d winner=%0d cycle=%0d",
                 last_state, state_o, start, prescaler, winner, cycle);
        chk("state", int'(state_o), e.st);
        chk("start", int'(start), e.sta);
        chk("prescaler", int'(prescaler), e.pr);
        chk("winner", int'(winner), e.wn);
        if (prev_dwell >= 0) chk("dwell", cycle - last_cycle, prev_dwell);
        prev_dwell = e.dw;
      end
      last_cycle = cycle;
      last_state = state_o;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press_btn();
    btn_start = 1'b1; tick(10);
    btn_start = 1'b0; tick(10);
  endtask

  task automatic chatter(int len);
    btn_start = 1'b1; tick(len);
    btn_start = 1'b0; tick(12);
  endtask

  task automatic wait_state(int s);
    int n;
    n = 0;
    while ((int'(state_o) != s) && (n < 300)) begin
      tick(1);
      n++;
    end
    chk("wait_state", int'(state_o), s);
  endtask

  task automatic do_point();
    int who;
    who = int'($urandom_range(0, 1));
    npts++;
    push(4, 0, model_presc(npts), 0, PD);
    push(2, 1, model_presc(npts), 0, -1);
    if (who == 1) p1_score = p1_score + 4'd1;
    else p2_score = p2_score + 4'd1;
    wait_state(4);
    wait_state(2);
    tick(int'($urandom_range(1, 5)));
  endtask

  initial begin
    int w;
    int n;
    tick(3);
    chk("rst_state", int'(state_o), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_presc", int'(prescaler), PI);
    chk("rst_winner", int'(winner), 0);
    RST_N = 1'b1;
    tick(2);

    chatter(3);
    chatter(int'($urandom_range(1, 2)));
    p1_score = 4'd3; tick(4);
    p1_score = 4'd0; tick(4);

    for (int g = 0; g < 2; g++) begin
      npts = 0;
      p1_score = 4'd0; p2_score = 4'd0;
      tick(2);
      push(1, 0, PI, 0, SD);
      push(2, 1, PI, 0, -1);
      press_btn();
      wait_state(2);
      gamestop = 1'b0;
      tick(4);
      n = 4 + int'($urandom_range(0, 2));
      for (int k = 0; k < n; k++) do_point();

      push(3, 0, model_presc(npts), 0, -1);
      press_btn();
      wait_state(3);
      p2_score = p2_score + 4'd1;
      tick(3);
      chatter(int'($urandom_range(1, 2)));
      push(2, 1, model_presc(npts), 0, -1);
      press_btn();
      wait_state(2);
      chatter(int'($urandom_range(1, 2)));

      // Ball block zeroes the scores in the same cycle it raises gamestop.
      w = (p1_score > p2_score) ? 1 : 2;
      push(5, 0, model_presc(npts), w, -1);
      p1_score = 4'd0; p2_score = 4'd0; gamestop = 1'b1;
      tick(8);
      push(0, 0, model_presc(npts), w, -1);
      press_btn();
      wait_state(0);
    end

    gamestop = 1'b0;
    tick(2);
    npts = 0;
    push(1, 0, PI, 0, SD);
    push(2, 1, PI, 0, -1);
    press_btn();
    wait_state(2);
    push(4, 0, model_presc(1), 0, -1);
    p2_score = p2_score + 4'd1;
    wait_state(4);
    tick(2);
    #2;
    push(0, 0, PI, 0, -1);
    RST_N = 1'b0;
    #1;
    chk("async_rst_state", int'(state_o), 0);
    chk("async_rst_start", int'(start), 0);
    chk("async_rst_presc", int'(prescaler), PI);
    chk("async_rst_winner", int'(winner), 0);
    tick(3);
    RST_N = 1'b1;
    tick(3);
    p1_score = 4'd0; p2_score = 4'd0;
    tick(2);
    push(1, 0, PI, 0, SD);
    push(2, 1, PI, 0, -1);
    press_btn();
    wait_state(2);
    tick(10);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
